// File: rtl/libv_base_pkg.sv
// Shared constants and helpers for the libv_base arithmetic blocks.
// sat_fn works on a sign-extended SAT_W-bit value so one function serves every width.
package libv_base_pkg;

    localparam logic [31:0] MODE_DUMP = "DUMP";
    localparam logic [31:0] MODE_RUN  = "RUN";
    localparam int          SAT_W     = 64;

    function automatic int clog2_fn(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Returns {ovf, value}; value is x if it fits in wo signed bits, else the rail.
    function automatic logic [SAT_W:0] sat_fn(input logic [SAT_W-1:0] x, input int wo);
        logic signed [SAT_W-1:0] hi;
        logic [SAT_W-1:0]        max_v;
        hi    = $signed(x) >>> (wo - 1);
        max_v = (SAT_W'(1) << (wo - 1)) - SAT_W'(1);
        if (hi == '0 || hi == '1) begin
            return {1'b0, x};
        end
        return {1'b1, x[SAT_W-1] ? ~max_v : max_v};
    endfunction

endpackage

// File: rtl/libv_base_sat.sv
// Combinational signed saturation from WIN to WOUT bits with a clip flag.
// Sign-extends when WOUT >= WIN, in which case o_ovf is always 0.
module libv_base_sat
    import libv_base_pkg::*;
#(
    parameter int WIN  = 9,
    parameter int WOUT = 8
) (
    input  logic [WIN-1:0]  i_x,
    output logic [WOUT-1:0] o_y,
    output logic            o_ovf
);

    logic [SAT_W-1:0] x_ext;
    logic [SAT_W:0]   sat_res;
    logic             sat_unused;

    always_comb begin
        x_ext   = SAT_W'($signed(i_x));
        sat_res = sat_fn(x_ext, WOUT);
    end

    assign o_y        = sat_res[WOUT-1:0];
    assign o_ovf      = sat_res[SAT_W];
    assign sat_unused = ^sat_res[SAT_W-1:WOUT];

endmodule

// File: rtl/libv_base_sacc.sv
// Signed saturating accumulate-and-dump (DUMP) or running accumulator (RUN)
// with a one-deep valid/ready output register.
module libv_base_sacc
    import libv_base_pkg::*;
#(
    parameter int          WI   = 8,
    parameter int          WO   = 8,
    parameter int          LEN  = 4,
    parameter logic [31:0] MODE = MODE_DUMP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [WI-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [WO-1:0] o_data,
    output logic          o_ovf
);

    localparam int WACC     = WI + clog2_fn(LEN);
    localparam int WCNT     = clog2_fn(LEN);
    localparam bit RUN_MODE = (MODE == MODE_RUN);

    logic [WACC-1:0] acc_q, acc_d;
    logic [WCNT-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [WO-1:0]   out_data_q, out_data_d;
    logic            out_ovf_q, out_ovf_d;

    logic [WACC:0]   sum;
    logic [WACC-1:0] acc_next;
    logic [WO-1:0]   res_data;
    logic            res_ovf;
    logic            accept;
    logic            frame_done;

    // One guard bit above the accumulator keeps the add exact before clipping.
    assign sum = {acc_q[WACC-1], acc_q} + (WACC+1)'($signed(i_data));

    generate
        if (RUN_MODE) begin : g_run
            logic acc_ovf;
            logic wo_ovf;
            libv_base_sat #(.WIN(WACC + 1), .WOUT(WACC)) u_acc_sat (
                .i_x   (sum),
                .o_y   (acc_next),
                .o_ovf (acc_ovf)
            );
            libv_base_sat #(.WIN(WACC), .WOUT(WO)) u_out_sat (
                .i_x   (acc_next),
                .o_y   (res_data),
                .o_ovf (wo_ovf)
            );
            assign res_ovf = acc_ovf | wo_ovf;
        end else begin : g_dump
            libv_base_sat #(.WIN(WACC + 1), .WOUT(WO)) u_out_sat (
                .i_x   (sum),
                .o_y   (res_data),
                .o_ovf (res_ovf)
            );
            assign acc_next = sum[WACC-1:0];
        end
    endgenerate

    assign i_ready    = !out_valid_q || o_ready;
    assign accept     = i_valid && i_ready;
    assign frame_done = RUN_MODE || (cnt_q == WCNT'(LEN - 1));

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && o_ready) begin
            out_valid_d = 1'b0;
        end

        // clr wins over a same-cycle accept; that sample is dropped.
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (frame_done) begin
                out_valid_d = 1'b1;
                out_data_d  = res_data;
                out_ovf_d   = res_ovf;
                acc_d       = RUN_MODE ? acc_next : '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + WCNT'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;
    assign o_ovf   = out_ovf_q;

endmodule

// File: tb/tb_libv_base_sacc.sv
// Directed bench: two DUMP instances (WO=8, WO=10) sharing stimulus, one RUN instance.
module tb_libv_base_sacc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       d_clr = 1'b0, d_valid = 1'b0, d_ready = 1'b1;
    logic [7:0] d_data = '0;
    logic       d8_iready, d8_valid, d8_ovf;
    logic [7:0] d8_data;
    logic       d10_iready, d10_valid, d10_ovf;
    logic [9:0] d10_data;

    logic       r_clr = 1'b0, r_valid = 1'b0, r_ready = 1'b1;
    logic [7:0] r_data_in = '0;
    logic       r_iready, r_valid_o, r_ovf;
    logic [7:0] r_data;

    int n_checks = 0;
    int n_fail   = 0;

    libv_base_sacc #(.WI(8), .WO(8), .LEN(4), .MODE("DUMP")) u_d8 (
        .clk(clk), .rst(rst), .clr(d_clr),
        .i_valid(d_valid), .i_ready(d8_iready), .i_data(d_data),
        .o_valid(d8_valid), .o_ready(d_ready), .o_data(d8_data), .o_ovf(d8_ovf)
    );

    libv_base_sacc #(.WI(8), .WO(10), .LEN(4), .MODE("DUMP")) u_d10 (
        .clk(clk), .rst(rst), .clr(d_clr),
        .i_valid(d_valid), .i_ready(d10_iready), .i_data(d_data),
        .o_valid(d10_valid), .o_ready(d_ready), .o_data(d10_data), .o_ovf(d10_ovf)
    );

    libv_base_sacc #(.WI(8), .WO(8), .LEN(4), .MODE("RUN")) u_run (
        .clk(clk), .rst(rst), .clr(r_clr),
        .i_valid(r_valid), .i_ready(r_iready), .i_data(r_data_in),
        .o_valid(r_valid_o), .o_ready(r_ready), .o_data(r_data), .o_ovf(r_ovf)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_d(input int x);
        d_valid = 1'b1;
        d_data  = 8'(x);
        cyc();
        d_valid = 1'b0;
        $display("dump push %0d -> o_valid=%0b o_data=%0d o_ovf=%0b", x, d8_valid,
                 $signed(d8_data), d8_ovf);
    endtask

    task automatic frame_d(input int a, input int b, input int c, input int d);
        push_d(a);
        push_d(b);
        push_d(c);
        check("partial_no_output", d8_valid, 0);
        push_d(d);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int rin [10] = '{100, 100, 100, 100, 100, 100, -128, -128, -128, -128};
    int rexp[10] = '{100, 127, 127, 127, 127, 127, 127, 127, 127, -1};
    int rovf[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", d8_valid, 0);
        check("rst_data", $signed(d8_data), 0);
        check("rst_ovf", d8_ovf, 0);
        check("rst_iready", d8_iready, 1);
        check("rst_run_valid", r_valid_o, 0);

        frame_d(10, 20, 30, 40);
        check("sum_valid", d8_valid, 1);
        check("sum_data", $signed(d8_data), 100);
        check("sum_ovf", d8_ovf, 0);
        check("sum_w10", $signed(d10_data), 100);
        cyc();
        check("sum_one_cycle", d8_valid, 0);

        frame_d(100, 100, 100, 100);
        check("pos_clip_data", $signed(d8_data), 127);
        check("pos_clip_ovf", d8_ovf, 1);
        check("pos_w10_data", $signed(d10_data), 400);
        check("pos_w10_ovf", d10_ovf, 0);
        cyc();

        frame_d(-128, -128, -128, -128);
        check("neg_clip_data", $signed(d8_data), -128);
        check("neg_clip_ovf", d8_ovf, 1);
        check("neg_w10_data", $signed(d10_data), -512);
        check("neg_w10_ovf", d10_ovf, 0);
        cyc();

        // Backpressure: result held, next sample stalls until o_ready returns.
        d_ready = 1'b0;
        frame_d(1, 2, 3, 4);
        check("bp_first_valid", d8_valid, 1);
        d_valid = 1'b1;
        d_data  = 8'd5;
        repeat (3) cyc();
        check("bp_iready_low", d8_iready, 0);
        check("bp_hold_valid", d8_valid, 1);
        check("bp_hold_data", $signed(d8_data), 10);
        d_ready = 1'b1;
        #1;
        check("bp_iready_comb", d8_iready, 1);
        cyc();
        d_valid = 1'b0;
        check("bp_drained", d8_valid, 0);
        push_d(6);
        push_d(7);
        push_d(8);
        check("bp_second_valid", d8_valid, 1);
        check("bp_second_data", $signed(d8_data), 26);
        cyc();

        // clr after two samples drops the partial sum and its own-cycle sample.
        push_d(5);
        push_d(5);
        d_clr   = 1'b1;
        d_valid = 1'b1;
        d_data  = 8'd99;
        cyc();
        d_clr   = 1'b0;
        d_valid = 1'b0;
        check("clr_no_output", d8_valid, 0);
        frame_d(1, 2, 3, 4);
        check("clr_data", $signed(d8_data), 10);
        cyc();

        // Asynchronous reset clears a pending result without a clock edge.
        d_ready = 1'b0;
        frame_d(2, 2, 2, 2);
        check("pre_rst_data", $signed(d8_data), 8);
        pulse_reset();
        check("arst_valid", d8_valid, 0);
        check("arst_data", $signed(d8_data), 0);
        check("arst_w10_data", $signed(d10_data), 0);
        check("arst_iready", d8_iready, 1);
        release_reset();
        d_ready = 1'b1;
        push_d(9);
        push_d(9);
        pulse_reset();
        release_reset();
        frame_d(1, 2, 3, 4);
        check("post_rst_data", $signed(d8_data), 10);
        check("post_rst_ovf", d8_ovf, 0);
        cyc();

        // RUN mode: back-to-back accepts with simultaneous drain and reload.
        r_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r_data_in = 8'(rin[i]);
            cyc();
            $display("run push %0d -> o_valid=%0b o_data=%0d o_ovf=%0b", rin[i], r_valid_o,
                     $signed(r_data), r_ovf);
            check($sformatf("run_valid_%0d", i), r_valid_o, 1);
            check($sformatf("run_data_%0d", i), $signed(r_data), rexp[i]);
            check($sformatf("run_ovf_%0d", i), r_ovf, rovf[i]);
        end
        r_valid = 1'b0;
        cyc();
        check("run_drained", r_valid_o, 0);
        r_clr = 1'b1;
        cyc();
        r_clr   = 1'b0;
        r_ready = 1'b0;
        r_valid = 1'b1;
        r_data_in = 8'd5;
        cyc();
        r_valid = 1'b0;
        check("run_clr_data", $signed(r_data), 5);
        check("run_bp_iready", r_iready, 0);
        r_ready = 1'b1;
        cyc();
        check("run_bp_drained", r_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
